// File: rtl/ex_mem_pipe_if.sv
// EX->MEM boundary bundle: EX-side handshake/payload, MEM-side head entry and fetch redirect.
// The stage itself connects through 'master'; the surrounding pipeline (or a bench) uses 'slave'.
interface ex_mem_pipe_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs2_data;
    logic [RA_W-1:0] ex_rd;
    logic [5:0]      ex_ctrl;
    logic [2:0]      ex_funct3;
    logic            flush;
    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_store_data;
    logic [XLEN-1:0] mem_pc_plus4;
    logic [RA_W-1:0] mem_rd;
    logic [3:0]      mem_ctrl;
    logic [2:0]      mem_funct3;
    logic            mem_exc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        input  alu_result, alu_zero, ex_valid, ex_pc, ex_imm, ex_rs2_data, ex_rd,
               ex_ctrl, ex_funct3, flush, mem_ready,
        output ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_pc_plus4,
               mem_rd, mem_ctrl, mem_funct3, mem_exc, redirect_valid, redirect_pc
    );

    modport slave (
        output alu_result, alu_zero, ex_valid, ex_pc, ex_imm, ex_rs2_data, ex_rd,
               ex_ctrl, ex_funct3, flush, mem_ready,
        input  ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_pc_plus4,
               mem_rd, mem_ctrl, mem_funct3, mem_exc, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM stage: 2-entry skid buffer with branch/jump resolution and a one-cycle fetch redirect.
// Optional EXMEM_MISALIGN_TRAP_EN: misaligned taken targets trap into the entry instead of redirecting.
module ex_mem_pipe #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    ex_mem_pipe_if.master bus
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] sdata;
        logic [XLEN-1:0] pc4;
        logic [RA_W-1:0] rd;
        logic [3:0]      ctrl;
        logic [2:0]      f3;
        logic            exc;
    } entry_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]      count_q, count_d;
    entry_t          slot0_q, slot0_d;
    entry_t          slot1_q, slot1_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    logic            c_reg_write, c_mem_read, c_mem_write, c_branch, c_jal, c_jalr;
    logic            take, trap, push, pop, ready, valid;
    logic [XLEN-1:0] target_raw, redir_tgt;
    entry_t          new_entry;

    assign {c_reg_write, c_mem_read, c_mem_write, c_branch, c_jal, c_jalr} = bus.ex_ctrl;

    // Ready depends only on occupancy, so mem_ready never reaches ex_ready combinationally.
    assign ready = (count_q != ST_TWO);
    assign valid = (count_q != ST_EMPTY);
    assign push  = bus.ex_valid & ready & ~bus.flush;
    assign pop   = valid & bus.mem_ready;

    always_comb begin
        take       = (c_branch & bus.alu_zero) | c_jal | c_jalr;
        target_raw = c_jalr ? {bus.alu_result[XLEN-1:1], 1'b0} : (bus.ex_pc + bus.ex_imm);
`ifdef EXMEM_MISALIGN_TRAP_EN
        trap      = take & (target_raw[1:0] != 2'b00);
        redir_tgt = target_raw;
`else
        trap      = 1'b0;
        redir_tgt = {target_raw[XLEN-1:2], 2'b00};
`endif
        new_entry.result = trap ? target_raw : bus.alu_result;
        new_entry.sdata  = bus.ex_rs2_data;
        new_entry.pc4    = bus.ex_pc + XLEN'(4);
        new_entry.rd     = bus.ex_rd;
        new_entry.ctrl   = {c_reg_write & ~trap, c_mem_read & ~trap, c_mem_write & ~trap,
                            c_jal | c_jalr};
        new_entry.f3     = bus.ex_funct3;
        new_entry.exc    = trap;
    end

    always_comb begin
        count_d       = count_q;
        slot0_d       = slot0_q;
        slot1_d       = slot1_q;
        redir_valid_d = push & take & ~trap;
        redir_pc_d    = redir_pc_q;
        if (push & take & ~trap) begin
            redir_pc_d = redir_tgt;
        end
        // Flush empties the buffer; push is already suppressed so no redirect is raised.
        if (bus.flush) begin
            count_d = ST_EMPTY;
        end else begin
            case (count_q)
                ST_EMPTY: begin
                    if (push) begin
                        slot0_d = new_entry;
                        count_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        slot0_d = new_entry;
                    end else if (push) begin
                        slot1_d = new_entry;
                        count_d = ST_TWO;
                    end else if (pop) begin
                        count_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        slot0_d = slot1_q;
                        count_d = ST_ONE;
                    end
                end
                default: count_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q       <= ST_EMPTY;
            slot0_q       <= '0;
            slot1_q       <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            count_q       <= count_d;
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign bus.ex_ready       = ready;
    assign bus.mem_valid      = valid;
    assign bus.mem_alu_result = slot0_q.result;
    assign bus.mem_store_data = slot0_q.sdata;
    assign bus.mem_pc_plus4   = slot0_q.pc4;
    assign bus.mem_rd         = slot0_q.rd;
    assign bus.mem_ctrl       = slot0_q.ctrl;
    assign bus.mem_funct3     = slot0_q.f3;
    assign bus.mem_exc        = slot0_q.exc;
    assign bus.redirect_valid = redir_valid_q;
    assign bus.redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe with an occupancy model and an expected-entry queue.
// Honors EXMEM_MISALIGN_TRAP_EN the same way the design does when compiled with it.
module tb_ex_mem_pipe;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic [2:0]  f3;
        logic        exc;
    } ent_t;

    // ex_ctrl encodings {reg_write, mem_read, mem_write, branch, jal, jalr}
    localparam logic [5:0] C_ALU  = 6'b100000;
    localparam logic [5:0] C_LD   = 6'b110000;
    localparam logic [5:0] C_ST   = 6'b001000;
    localparam logic [5:0] C_BR   = 6'b000100;
    localparam logic [5:0] C_JAL  = 6'b100010;
    localparam logic [5:0] C_JALR = 6'b100001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_mem_pipe_if #(.XLEN(32), .RA_W(5)) bus ();

    ex_mem_pipe #(.XLEN(32), .RA_W(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    int   total = 0;
    int   bad   = 0;
    int   mcount = 0;
    ent_t sb[$];
    logic exp_rv = 1'b0;
    logic [31:0] exp_rpc = 32'h0;
    logic last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] alu, input logic zero, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic [5:0] ctl, input logic [2:0] f3);
        bus.alu_result  = alu;
        bus.alu_zero    = zero;
        bus.ex_pc       = pc;
        bus.ex_imm      = imm;
        bus.ex_rs2_data = rs2;
        bus.ex_rd       = rd;
        bus.ex_ctrl     = ctl;
        bus.ex_funct3   = f3;
    endtask

    // One clock of the model: check outputs at the falling edge, then advance expectations.
    task automatic tick();
        logic        acc, popm, taken, misal;
        logic [31:0] tgt;
        ent_t        e, h;
        @(negedge clk);
        chk("ex_ready", {31'b0, bus.ex_ready}, {31'b0, (mcount != 2)});
        chk("mem_valid", {31'b0, bus.mem_valid}, {31'b0, (mcount != 0)});
        chk("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("redirect_pc", bus.redirect_pc, exp_rpc);
        if (mcount != 0 && sb.size() != 0) begin
            h = sb[0];
            chk("mem_alu_result", bus.mem_alu_result, h.res);
            chk("mem_store_data", bus.mem_store_data, h.sd);
            chk("mem_pc_plus4", bus.mem_pc_plus4, h.pc4);
            chk("mem_rd", {27'b0, bus.mem_rd}, {27'b0, h.rd});
            chk("mem_ctrl", {28'b0, bus.mem_ctrl}, {28'b0, h.ctl});
            chk("mem_funct3", {29'b0, bus.mem_funct3}, {29'b0, h.f3});
            chk("mem_exc", {31'b0, bus.mem_exc}, {31'b0, h.exc});
        end
        acc   = bus.ex_valid && (mcount != 2) && !bus.flush;
        popm  = (mcount != 0) && bus.mem_ready;
        taken = (bus.ex_ctrl[2] && bus.alu_zero) || bus.ex_ctrl[1] || bus.ex_ctrl[0];
        tgt   = bus.ex_ctrl[0] ? (bus.alu_result & 32'hFFFF_FFFE) : (bus.ex_pc + bus.ex_imm);
`ifdef EXMEM_MISALIGN_TRAP_EN
        misal = taken && (tgt[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        e.res = misal ? tgt : bus.alu_result;
        e.sd  = bus.ex_rs2_data;
        e.pc4 = bus.ex_pc + 32'd4;
        e.rd  = bus.ex_rd;
        e.ctl = {misal ? 3'b000 : bus.ex_ctrl[5:3], bus.ex_ctrl[1] | bus.ex_ctrl[0]};
        e.f3  = bus.ex_funct3;
        e.exc = misal;
        if (bus.flush) begin
            sb.delete();
            mcount = 0;
            exp_rv = 1'b0;
        end else begin
            if (popm) void'(sb.pop_front());
            if (acc) sb.push_back(e);
            mcount = mcount + int'(acc) - int'(popm);
            exp_rv = acc && taken && !misal;
`ifdef EXMEM_MISALIGN_TRAP_EN
            if (exp_rv) exp_rpc = tgt;
`else
            if (exp_rv) exp_rpc = tgt & 32'hFFFF_FFFC;
`endif
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic send();
        int n = 0;
        bus.ex_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 12);
        if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
        bus.ex_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b1;
        // A taken JAL offered during reset must not be accepted nor redirect.
        set_in(32'h0, 1'b0, 32'h200, 32'h40, 32'h0, 5'd1, C_JAL, 3'd0);
        bus.ex_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
        chk("rst_ex_ready", {31'b0, bus.ex_ready}, 32'd1);
        chk("rst_mem_alu_result", bus.mem_alu_result, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.ex_valid = 1'b0;
        tick();

        // Pass-through ADD
        set_in(32'h0000_0010, 1'b0, 32'h80, 32'h0, 32'h0, 5'd5, C_ALU, 3'd0);
        send();
        tick();
        tick();

        // Backpressure: A, B fill the buffer, C waits upstream
        bus.mem_ready = 1'b0;
        set_in(32'hAAAA_0001, 1'b0, 32'h100, 32'h0, 32'h1111_1111, 5'd1, C_LD, 3'd2);
        send();
        set_in(32'hBBBB_0002, 1'b0, 32'h104, 32'h0, 32'h2222_2222, 5'd2, C_ST, 3'd1);
        send();
        set_in(32'hCCCC_0003, 1'b0, 32'h108, 32'h0, 32'h3333_3333, 5'd3, C_ALU, 3'd4);
        bus.ex_valid = 1'b1;
        tick();
        tick();
        bus.mem_ready = 1'b1;
        send();
        repeat (3) tick();

        // Branch taken with wrap-around target 0x100 + -16 = 0xF0, then not taken
        set_in(32'h0, 1'b1, 32'h100, 32'hFFFF_FFF0, 32'h0, 5'd0, C_BR, 3'd0);
        send();
        tick();
        tick();
        set_in(32'h0, 1'b0, 32'h100, 32'hFFFF_FFF0, 32'h0, 5'd0, C_BR, 3'd0);
        send();
        tick();
        tick();

        // JALR: bit0 cleared; the default build also clears bit1 of the redirect target
        set_in(32'h0000_2003, 1'b0, 32'h40, 32'h0, 32'h0, 5'd1, C_JALR, 3'd0);
        send();
        tick();
        tick();
        set_in(32'h0000_2006, 1'b0, 32'h40, 32'h0, 32'h0, 5'd1, C_JALR, 3'd0);
        send();
        tick();
        tick();
        // JAL redirect issued while MEM is stalled
        bus.mem_ready = 1'b0;
        set_in(32'h0, 1'b0, 32'h1000, 32'h0000_0800, 32'h0, 5'd1, C_JAL, 3'd0);
        send();
        tick();
        bus.mem_ready = 1'b1;
        tick();
        tick();

        // Flush: two held entries plus a taken JAL in the same cycle
        bus.mem_ready = 1'b0;
        set_in(32'h0000_0123, 1'b0, 32'h300, 32'h0, 32'h0, 5'd7, C_ALU, 3'd0);
        send();
        set_in(32'h0000_0456, 1'b0, 32'h304, 32'h0, 32'h0, 5'd8, C_ALU, 3'd0);
        send();
        set_in(32'h0, 1'b0, 32'h308, 32'h0000_0100, 32'h0, 5'd1, C_JAL, 3'd0);
        bus.ex_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.ex_valid = 1'b0;
        bus.flush    = 1'b0;
        tick();
        bus.mem_ready = 1'b1;
        tick();

        // Reset mid-operation discards held entries
        bus.mem_ready = 1'b0;
        set_in(32'h0000_0777, 1'b0, 32'h400, 32'h0, 32'h0, 5'd9, C_ALU, 3'd0);
        send();
        send();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        mcount = 0;
        exp_rv = 1'b0;
        tick();
        bus.mem_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
